ram_arbiter: RTL and testbench

Two-port arbiter that shares the single 4K×4 data RAM between the CPU datapath (port 0) and the host/debug loader (port 1). It serialises requests into fixed three-cycle RAM accesses with a req/ack handshake. It applies round-robin fairness with a bounded burst lock for the loader. The arbiter drives the RAM control pins and a write-data driver enable; the top level ties `ram_wdata`/`ram_drive` to a tri-state driver on the RAM data pins and feeds those pins back as `ram_rdata`.

---
 rtl/ram_arbiter.sv | 110 +++++++++++
 tb/tb_ram_arbiter.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/ram_arbiter.sv
// Two-port arbiter for the shared data RAM. Each access takes three cycles (IDLE, ACC, DONE).
// Contention is settled round-robin, and port 1 may hold a bounded burst lock.
module ram_arbiter #(
  parameter int ADDR_W   = 12,
  parameter int DATA_W   = 4,
  parameter int MAX_LOCK = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              req0,
  input  logic              req1,
  input  logic              we0,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata0,
  input  logic [DATA_W-1:0] wdata1,
  input  logic              lock1,
  output logic              ack0,
  output logic              ack1,
  output logic [DATA_W-1:0] rdata0,
  output logic [DATA_W-1:0] rdata1,
  output logic [1:0]        gnt,
  output logic              ram_cs,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  output logic              ram_drive,
  input  logic [DATA_W-1:0] ram_rdata
);

  typedef enum logic [1:0] {S_IDLE, S_ACC, S_DONE} state_t;

  localparam logic [3:0] LMAX = 4'(MAX_LOCK);

  state_t            r_state;
  logic              r_sel;       // granted port of the access in flight
  logic              r_we;
  logic              r_last;      // port granted most recently
  logic [3:0]        r_lock_cnt;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic [DATA_W-1:0] r_rdata0;
  logic [DATA_W-1:0] r_rdata1;

  logic w_lock_hold;
  logic w_pick1;
  logic w_acc;
  logic w_busy;

  // Port 1 keeps the RAM while its burst is still under the cap; otherwise the port that did not go last wins.
  assign w_lock_hold = lock1 && (r_lock_cnt != 4'd0) && (r_lock_cnt < LMAX);
  assign w_pick1     = req1 && (!req0 || w_lock_hold || !r_last);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_sel      <= 1'b0;
      r_we       <= 1'b0;
      r_last     <= 1'b1;
      r_lock_cnt <= 4'd0;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_rdata0   <= '0;
      r_rdata1   <= '0;
    end else begin
      case (r_state)
        S_IDLE: if (req0 || req1) begin
          r_sel   <= w_pick1;
          r_we    <= w_pick1 ? we1 : we0;
          r_addr  <= w_pick1 ? addr1 : addr0;
          r_wdata <= w_pick1 ? wdata1 : wdata0;
          r_state <= S_ACC;
        end
        S_ACC: begin
          if (!r_we) begin
            if (r_sel) r_rdata1 <= ram_rdata;
            else       r_rdata0 <= ram_rdata;
          end
          r_state <= S_DONE;
        end
        S_DONE: begin
          r_last <= r_sel;
          if (r_sel && lock1)
            r_lock_cnt <= (r_lock_cnt >= LMAX) ? LMAX : r_lock_cnt + 4'd1;
          else
            r_lock_cnt <= 4'd0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Every strobe is decoded from the state register, so reset clears it at once.
  assign w_acc  = (r_state == S_ACC);
  assign w_busy = (r_state != S_IDLE);

  assign gnt       = {w_busy & r_sel, w_busy & ~r_sel};
  assign ack0      = (r_state == S_DONE) & ~r_sel;
  assign ack1      = (r_state == S_DONE) &  r_sel;
  assign ram_cs    = w_acc;
  assign ram_we    = w_acc & r_we;
  assign ram_drive = ram_cs & ram_we;
  assign ram_addr  = r_addr;
  assign ram_wdata = r_wdata;
  assign rdata0    = r_rdata0;
  assign rdata1    = r_rdata1;

endmodule

// File: tb/tb_ram_arbiter.sv
// Directed bench for ram_arbiter. The stimulus pushes the expected acks (port, cycle, read data).
// A negedge monitor pops and checks each ack the DUT raises.
module tb_ram_arbiter;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        req0 = 0, req1 = 0, we0 = 0, we1 = 0, lock1 = 0;
  logic [11:0] addr0 = '0, addr1 = '0;
  logic [3:0]  wdata0 = '0, wdata1 = '0;
  logic        ack0, ack1, ram_cs, ram_we, ram_drive;
  logic [3:0]  rdata0, rdata1, ram_wdata, ram_rdata;
  logic [1:0]  gnt;
  logic [11:0] ram_addr;

  ram_arbiter #(.ADDR_W(12), .DATA_W(4), .MAX_LOCK(4)) dut (
    .clock(clock), .reset(reset),
    .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .lock1(lock1), .ack0(ack0), .ack1(ack1), .rdata0(rdata0), .rdata1(rdata1),
    .gnt(gnt), .ram_cs(ram_cs), .ram_we(ram_we), .ram_addr(ram_addr),
    .ram_wdata(ram_wdata), .ram_drive(ram_drive), .ram_rdata(ram_rdata)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  // RAM model with a few preset locations.
  logic [3:0] mem [0:4095];
  bit         mem_ok = 1'b0;
  function automatic logic [3:0] preset(input int a);
    case (a)
      'h005:   return 4'h3;
      'h010:   return 4'h1;
      'h020:   return 4'h2;
      'hFFF:   return 4'h6;
      default: return 4'h0;
    endcase
  endfunction
  always @(posedge clock) begin
    if (!mem_ok) begin
      for (int i = 0; i < 4096; i++) mem[i] <= preset(i);
      mem_ok <= 1'b1;
    end else if (ram_cs && ram_we) mem[ram_addr] <= ram_wdata;
  end
  assign ram_rdata = mem[ram_addr];

  typedef struct {
    int         port;
    bit         rd;
    logic [3:0] data;
    int         cyc;
  } exp_t;
  exp_t sb[$];

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push(input int p, input bit rd, input logic [3:0] d, input int c);
    exp_t e;
    e.port = p; e.rd = rd; e.data = d; e.cyc = c;
    sb.push_back(e);
  endtask

  task automatic at(input int t);
    while (cyc < t) @(negedge clock);
  endtask

  // Monitor: every ack must match the next scoreboard entry.
  always @(negedge clock) begin
    if (!reset && (ack0 || ack1)) begin
      if (ack0 && ack1) chk("ack_onehot", {ack1, ack0}, 2'b01);
      else if (sb.size() == 0) chk("unexpected_ack", {ack1, ack0}, 2'b00);
      else begin
        exp_t e;
        e = sb.pop_front();
        chk("ack_port", ack1 ? 1 : 0, e.port);
        chk("ack_cycle", cyc, e.cyc);
        if (e.rd) chk(e.port ? "rdata1" : "rdata0", ack1 ? rdata1 : rdata0, e.data);
      end
    end
  end

  // One uncontested access from idle; optionally drops req during ACC.
  task automatic xfer(input int p, input bit we, input logic [11:0] a,
                      input logic [3:0] wd, input logic [3:0] exp_rd, input bit drop_early);
    int c;
    @(negedge clock);
    c = cyc;
    if (p == 0) begin req0 = 1; we0 = we; addr0 = a; wdata0 = wd; end
    else        begin req1 = 1; we1 = we; addr1 = a; wdata1 = wd; end
    push(p, !we, exp_rd, c + 2);
    at(c + 1);
    chk("acc_cs", ram_cs, 1);
    chk("acc_we", ram_we, we);
    chk("acc_drive", ram_drive, we);
    chk("acc_addr", ram_addr, a);
    chk("acc_gnt", gnt, (p == 1) ? 2'b10 : 2'b01);
    if (we) chk("acc_wdata", ram_wdata, wd);
    if (drop_early) begin req0 = 0; req1 = 0; end
    at(c + 2);
    req0 = 0; req1 = 0;
    at(c + 3);
    chk("idle_cs", ram_cs, 0);
  endtask

  initial begin
    int c;
    repeat (3) @(negedge clock);
    chk("rst_gnt", gnt, 0);
    chk("rst_ack", {ack1, ack0}, 0);
    chk("rst_cs", {ram_cs, ram_we, ram_drive}, 0);
    chk("rst_rdata0", rdata0, 0);
    chk("rst_rdata1", rdata1, 0);
    chk("rst_addr", ram_addr, 0);
    reset = 0;

    // Contention straight after reset: port 0 wins first, then alternate.
    @(negedge clock);
    c = cyc;
    req0 = 1; we0 = 0; addr0 = 12'h010;
    req1 = 1; we1 = 0; addr1 = 12'h020;
    push(0, 1, 4'h1, c + 2); push(1, 1, 4'h2, c + 5);
    push(0, 1, 4'h1, c + 8); push(1, 1, 4'h2, c + 11);
    at(c + 1);  chk("cont_gnt0", gnt, 2'b01);
    at(c + 4);  chk("cont_gnt1", gnt, 2'b10);
    at(c + 8);  req0 = 0;
    at(c + 11); req1 = 0;
    at(c + 14);
    chk("cont_idle_gnt", gnt, 0);
    chk("cont_sb_empty", sb.size(), 0);

    // Write then read back on port 0.
    xfer(0, 1, 12'h123, 4'hA, 4'h0, 0);
    xfer(0, 0, 12'h123, 4'h0, 4'hA, 0);
    // Port isolation: a port 1 read leaves rdata0 untouched.
    xfer(1, 0, 12'h005, 4'h0, 4'h3, 0);
    chk("iso_rdata0", rdata0, 4'hA);
    chk("iso_rdata1", rdata1, 4'h3);
    // Early drop of req1 during ACC: the access still completes, with no second access.
    xfer(1, 0, 12'hFFF, 4'h0, 4'h6, 1);
    repeat (6) @(negedge clock);
    chk("drop_gnt_idle", gnt, 0);
    chk("drop_rdata1", rdata1, 4'h6);
    chk("drop_sb_empty", sb.size(), 0);

    // Burst lock: four port 1 grants in a row, then port 0 gets in and the count clears.
    @(negedge clock);
    c = cyc;
    lock1 = 1; req1 = 1; we1 = 0; addr1 = 12'h020;
    push(1, 1, 4'h2, c + 2);
    at(c + 2);
    req0 = 1; we0 = 0; addr0 = 12'h010;
    push(1, 1, 4'h2, c + 5); push(1, 1, 4'h2, c + 8); push(1, 1, 4'h2, c + 11);
    push(0, 1, 4'h1, c + 14);
    at(c + 14); req0 = 0;
    push(1, 1, 4'h2, c + 17);
    at(c + 17); req0 = 1;
    push(1, 1, 4'h2, c + 20); push(0, 1, 4'h1, c + 23);
    at(c + 20); req1 = 0; lock1 = 0;
    at(c + 23); req0 = 0;
    at(c + 26);
    chk("lock_sb_empty", sb.size(), 0);

    // Reset in the middle of an access: the strobes drop at once and no ack follows.
    @(negedge clock);
    c = cyc;
    req0 = 1; we0 = 1; addr0 = 12'h0F0; wdata0 = 4'h5;
    at(c + 1);
    chk("midrst_cs_before", ram_cs, 1);
    #2 reset = 1;
    #1;
    chk("midrst_cs", ram_cs, 0);
    chk("midrst_drive", ram_drive, 0);
    chk("midrst_gnt", gnt, 0);
    repeat (2) @(negedge clock);
    req0 = 0;
    chk("midrst_rdata0", rdata0, 0);
    chk("midrst_rdata1", rdata1, 0);
    chk("midrst_addr", ram_addr, 0);
    reset = 0;
    repeat (6) @(negedge clock);
    chk("midrst_no_ack_gnt", gnt, 0);
    chk("final_sb_empty", sb.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
